// File: rtl/kcpsm3_io_pkg.sv
// Shared definitions for KCPSM3 port-bus peripherals: register offsets,
// interrupt controller state encoding and VECT register layout.
package kcpsm3_io_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_VECT = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam int unsigned VECT_ACTIVE_BIT = 7;
  localparam int unsigned VECT_ID_MSB     = 2;
  localparam int unsigned VECT_ID_LSB     = 0;

  function automatic logic [7:0] vect_pack(input logic active, input logic [2:0] id);
    logic [7:0] v;
    v = '0;
    v[VECT_ACTIVE_BIT] = active;
    v[VECT_ID_MSB:VECT_ID_LSB] = id;
    return v;
  endfunction

endpackage

// File: rtl/kcpsm3_int_ctrl_rr_arb8.sv
// Combinational 8-way round-robin arbiter: search starts at ptr and wraps
// 7->0; the first requesting index found is granted.
module rr_arb8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] gnt_id,
  output logic       gnt_valid
);

  logic [2:0] idx;

  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/kcpsm3_int_ctrl.sv
// Eight-source edge-triggered interrupt controller for the KCPSM3 port bus:
// edge capture, PEND/MASK registers, round-robin grant, ack/EOI handshake.
module kcpsm3_int_ctrl
  import kcpsm3_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_in,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  state_e     state_q, state_d;
  logic [7:0] irq_prev_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] id_q, id_d;
  logic       active_q, active_d;
  logic       interrupt_q;
  logic [7:0] in_port_q, in_port_d;

  logic       win_hit, wr_hit, eoi_wr;
  logic [1:0] reg_off;
  logic [7:0] set, w1c, ackclr, cand, rdata;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  assign win_hit = (port_id[7:2] == BASE_ADDR[7:2]);
  assign reg_off = port_id[1:0];
  assign wr_hit  = write_strobe && win_hit;
  assign eoi_wr  = wr_hit && (reg_off == REG_EOI);
  assign w1c     = (wr_hit && (reg_off == REG_PEND)) ? out_port : '0;
  assign set     = irq_in & ~irq_prev_q;
  assign cand    = pend_q & mask_q;

  rr_arb8 u_arb (
    .req       (cand),
    .ptr       (rr_ptr_q),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    active_d = active_q;
    ackclr   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          id_d     = gnt_id;
          rr_ptr_d = gnt_id + 3'd1;
          state_d  = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // Only the ack leaves ASSERT; masking or W1C cannot withdraw it.
        if (interrupt_ack) begin
          ackclr[id_q] = 1'b1;
          active_d     = 1'b1;
          state_d      = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi_wr) begin
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // New edges win over same-cycle clears so no event is lost.
    pend_d = (pend_q & ~w1c & ~ackclr) | set;
    mask_d = (wr_hit && (reg_off == REG_MASK)) ? out_port : mask_q;
    unique case (reg_off)
      REG_PEND: rdata = pend_q;
      REG_MASK: rdata = mask_q;
      REG_VECT: rdata = vect_pack(active_q, id_q);
      default:  rdata = '0;
    endcase
    // Data is captured in the first INPUT cycle and frozen while the strobe is high.
    if (!win_hit)         in_port_d = '0;
    else if (read_strobe) in_port_d = in_port_q;
    else                  in_port_d = rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      irq_prev_q  <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      active_q    <= 1'b0;
      interrupt_q <= 1'b0;
      in_port_q   <= '0;
    end else begin
      state_q     <= state_d;
      irq_prev_q  <= irq_in;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      active_q    <= active_d;
      interrupt_q <= (state_d == ST_ASSERT);
      in_port_q   <= in_port_d;
    end
  end

  assign interrupt = interrupt_q;
  assign in_port   = in_port_q;

endmodule
